// File: rtl/sdspi_mem_dumper.sv
// Dumps BIN_SIZE bytes of memory as a little-endian byte stream for an SD sector writer,
// zero-padded to whole sectors, with a per-sector last-byte flag.
module sdspi_mem_dumper #(
  parameter logic [31:0] BIN_SIZE     = 32'h0001_0000,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          SECTOR_BYTES = 512
) (
  input  logic        clk27mhz,
  input  logic        rst,
  input  logic        start,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  input  logic        rd_ack,
  output logic [7:0]  outbyte,
  output logic        outen,
  input  logic        out_ready,
  output logic        sector_last,
  output logic        BUSY,
  output logic        DONE
);
  localparam int SW = $clog2(SECTOR_BYTES);
  localparam logic [SW-1:0] SEC_LAST = SW'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {IDLE, REQ, SEND, PAD, FIN} state_t;
  state_t state;

  logic [31:0]   word, byte_cnt;
  logic [SW-1:0] sec_cnt;
  logic [1:0]    lane;

  logic          xfer;
  logic [1:0]    lane_nxt;
  logic [31:0]   byte_nxt;
  logic [SW-1:0] sec_nxt;
  assign xfer     = outen && out_ready;
  assign lane_nxt = lane + 2'd1;
  assign byte_nxt = byte_cnt + 32'd1;
  assign sec_nxt  = sec_cnt + SW'(1);

  always_ff @(posedge clk27mhz) begin
    if (rst) begin
      state       <= IDLE;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      outbyte     <= '0;
      outen       <= 1'b0;
      sector_last <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      word        <= '0;
      byte_cnt    <= '0;
      sec_cnt     <= '0;
      lane        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          BUSY     <= 1'b1;
          DONE     <= 1'b0;
          rd_addr  <= BASE_ADDR;
          byte_cnt <= '0;
          sec_cnt  <= '0;
          lane     <= '0;
          state    <= REQ;
        end
        // rd_req rises one cycle after entry, so an ack arriving while it is low is stale
        REQ: begin
          if (!rd_req) rd_req <= 1'b1;
          else if (rd_ack) begin
            rd_req      <= 1'b0;
            word        <= rd_data;
            lane        <= '0;
            outen       <= 1'b1;
            outbyte     <= rd_data[7:0];
            sector_last <= (sec_cnt == SEC_LAST);
            state       <= SEND;
          end
        end
        SEND: if (xfer) begin
          lane     <= lane_nxt;
          byte_cnt <= byte_nxt;
          sec_cnt  <= sec_nxt;
          if (lane == 2'd3) begin
            if (byte_nxt < BIN_SIZE) begin
              rd_addr     <= rd_addr + 32'd4;
              outen       <= 1'b0;
              sector_last <= 1'b0;
              state       <= REQ;
            end else if (sec_nxt == '0) begin
              outen       <= 1'b0;
              sector_last <= 1'b0;
              state       <= FIN;
            end else begin
              outbyte     <= 8'h00;
              sector_last <= (sec_nxt == SEC_LAST);
              state       <= PAD;
            end
          end else begin
            outbyte     <= word[{lane_nxt, 3'b000} +: 8];
            sector_last <= (sec_nxt == SEC_LAST);
          end
        end
        PAD: if (xfer) begin
          sec_cnt <= sec_nxt;
          if (sec_nxt == '0) begin
            outen       <= 1'b0;
            sector_last <= 1'b0;
            state       <= FIN;
          end else begin
            sector_last <= (sec_nxt == SEC_LAST);
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdspi_mem_dumper.sv
// Two dumper instances (one padding with a wrapping base address, one exact-fit) driven by
// shared start/reset/backpressure, each checked against a byte/address scoreboard.
module tb_sdspi_mem_dumper;
  localparam logic [31:0] BSZ [2] = '{32'd24, 32'd32};
  localparam logic [31:0] BAS [2] = '{32'hFFFF_FFF0, 32'h0000_0100};
  localparam int          SBZ [2] = '{16, 16};

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [1:0]        rd_req, rd_ack, outen, sector_last, busy, done;
  logic [1:0][31:0]  rd_addr, rd_data;
  logic [1:0][7:0]   outbyte;

  int total = 0;
  int bad   = 0;
  int nacc [2];
  logic hold_ack = 1'b0;
  logic rnd_rdy  = 1'b0;
  logic [8:0]  exp_q  [2][$];
  logic [31:0] addr_q [2][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdspi_mem_dumper #(.BIN_SIZE(BSZ[g]), .BASE_ADDR(BAS[g]), .SECTOR_BYTES(SBZ[g])) u_dut (
      .clk27mhz(clk), .rst(rst), .start(start),
      .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]), .rd_ack(rd_ack[g]),
      .outbyte(outbyte[g]), .outen(outen[g]), .out_ready(out_ready),
      .sector_last(sector_last[g]), .BUSY(busy[g]), .DONE(done[g])
    );
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a dump is accepted only when nothing is outstanding for that instance.
  task automatic model_start();
    logic [31:0] w, tot;
    logic [7:0]  b;
    for (int g = 0; g < 2; g++) begin
      if (exp_q[g].size() != 0) continue;
      tot = ((BSZ[g] + SBZ[g] - 1) / SBZ[g]) * SBZ[g];
      for (int unsigned i = 0; i < tot; i++) begin
        w = mem_word(BAS[g] + 32'(4 * (i / 4)));
        b = (i < BSZ[g]) ? w[8 * (i % 4) +: 8] : 8'h00;
        exp_q[g].push_back({(i % SBZ[g]) == SBZ[g] - 1, b});
      end
      for (int unsigned k = 0; k < BSZ[g] / 4; k++) addr_q[g].push_back(BAS[g] + 32'(4 * k));
      nacc[g] = 0;
    end
  endtask

  task automatic do_start(input bit lat_chk);
    @(posedge clk); #1 start = 1'b1;
    model_start();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    if (lat_chk) begin
      chk("busy_after_start", {busy, done}, 4'b1100);
      chk("rd_req_early", rd_req, 2'b00);
      @(negedge clk);
      chk("rd_req_2cyc", rd_req, 2'b11);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    for (int g = 0; g < 2; g++) begin exp_q[g].delete(); addr_q[g].delete(); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk($sformatf("reset_outs%0d", g),
          {rd_req[g], outen[g], sector_last[g], busy[g], done[g], outbyte[g], rd_addr[g]}, '0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 2'b11 && n < 3000) begin @(negedge clk); n++; end
    chk("done_reached", done, 2'b11);
    chk("busy_cleared", busy, 2'b00);
    chk("bytes_left", exp_q[0].size() + exp_q[1].size(), 0);
    chk("reads_left", addr_q[0].size() + addr_q[1].size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1 out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_chk
    // Memory responder: random ack delay, address checked against the expected read order.
    initial begin
      logic [31:0] a, ea;
      int d;
      rd_ack[g] = 1'b0; rd_data[g] = '0;
      forever begin
        @(negedge clk);
        if (rd_req[g] && !rst) begin
          a = rd_addr[g];
          ea = (addr_q[g].size() != 0) ? addr_q[g].pop_front() : ~a;
          chk($sformatf("rd_addr%0d", g), a, ea);
          d = $urandom_range(0, 5);
          while (hold_ack) @(negedge clk);
          repeat (d) begin
            @(negedge clk);
            if (rd_req[g] && rd_addr[g] !== a) chk($sformatf("rd_addr_stable%0d", g), rd_addr[g], a);
          end
          @(posedge clk); #1 rd_ack[g] = 1'b1; rd_data[g] = mem_word(a);
          @(posedge clk); #1 rd_ack[g] = 1'b0;
        end
      end
    end

    // Stream monitor: pops the scoreboard on every accepted byte and checks stall stability.
    initial begin
      logic stall = 1'b0;
      logic [8:0] held, e;
      forever begin
        @(negedge clk);
        if (rst) begin stall = 1'b0; continue; end
        if (stall) chk($sformatf("stall_hold%0d", g), {outen[g], sector_last[g], outbyte[g]}, {1'b1, held});
        if (outen[g] && out_ready) begin
          e = (exp_q[g].size() != 0) ? exp_q[g].pop_front() : 9'h1FF;
          chk($sformatf("byte%0d_%0d", g, nacc[g]), {sector_last[g], outbyte[g]}, e);
          nacc[g]++;
        end
        stall = outen[g] && !out_ready;
        held  = {sector_last[g], outbyte[g]};
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    nacc[0] = 0; nacc[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {rd_req, outen, sector_last, busy, done}, '0);

    // full-rate dump with latency check
    do_start(1'b1);
    wait_done();

    // backpressure, restart after DONE, and an ignored mid-dump start
    rnd_rdy = 1'b1;
    do_start(1'b1);
    repeat (15) @(negedge clk);
    do_start(1'b0);
    wait_done();

    // reset while instance 0 is padding
    do_start(1'b0);
    n = 0;
    while (nacc[0] < 26 && n < 2000) begin @(negedge clk); n++; end
    chk("reached_pad", nacc[0] >= 26, 1'b1);
    do_reset();

    // reset while a read is pending, then a late ack that must be ignored
    hold_ack = 1'b1;
    do_start(1'b0);
    n = 0;
    while (rd_req !== 2'b11 && n < 100) begin @(negedge clk); n++; end
    chk("req_pending", rd_req, 2'b11);
    do_reset();
    hold_ack = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("late_ack_ignored", {rd_req, outen, busy}, '0);
    end

    // fresh dump after reset
    do_start(1'b1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
